// File: rtl/cpu_icache_burst.sv
// Direct-mapped instruction cache with multi-word lines, burst refill and
// a full-cache invalidate sweep between the fetch stage and the instruction bus.
module cpu_icache_burst #(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_input_pc,
  input  logic        i_stall,
  input  logic        i_invalidate,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata
);

  localparam int unsigned W      = $clog2(LINE_WORDS);
  localparam int unsigned OW     = (W == 0) ? 1 : W;
  localparam int unsigned TW     = 30 - W - INDEX_BITS;
  localparam int unsigned DAW    = INDEX_BITS + W;
  localparam int unsigned LINES  = 1 << INDEX_BITS;
  localparam int unsigned DWORDS = 1 << DAW;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]           r_pc;
  logic                  r_pending;
  logic [INDEX_BITS-1:0] r_clr_cnt;
  logic [OW-1:0]         r_fill_cnt;
  logic [31:0]           r_ret;
  logic [31:0]           r_bus_address;

  logic                  r_valid    [LINES];
  logic [TW-1:0]         r_tag_mem  [LINES];
  logic [31:0]           r_data_mem [DWORDS];
  logic                  r_rd_valid;
  logic [TW-1:0]         r_rd_tag;
  logic [31:0]           r_rd_word;

  logic [INDEX_BITS-1:0] w_index;
  logic [INDEX_BITS-1:0] w_acc_index;
  logic [OW-1:0]         w_offset;
  logic [OW-1:0]         w_acc_offset;
  logic [TW-1:0]         w_tag;
  logic [DAW-1:0]        w_fill_daddr;
  logic [DAW-1:0]        w_acc_daddr;
  logic [31:0]           w_line_base;
  logic                  w_is_last;
  logic                  w_accept;
  logic                  w_miss;
  logic                  w_word_done;
  logic                  w_ready;
  logic [31:0]           w_rdata;

  // Address split; offset is forced to zero for single-word lines
  assign w_index      = INDEX_BITS'(r_pc >> (W + 2));
  assign w_acc_index  = INDEX_BITS'(i_input_pc >> (W + 2));
  assign w_offset     = (W == 0) ? '0 : OW'(r_pc >> 2);
  assign w_acc_offset = (W == 0) ? '0 : OW'(i_input_pc >> 2);
  assign w_tag        = TW'(r_pc >> (W + INDEX_BITS + 2));
  assign w_fill_daddr = DAW'(32'(w_index) << W) | DAW'(r_fill_cnt);
  assign w_acc_daddr  = DAW'(32'(w_acc_index) << W) | DAW'(w_acc_offset);
  assign w_line_base  = r_pc & ~(32'(LINE_WORDS * 4) - 32'd1);
  assign w_is_last    = (r_fill_cnt == OW'(LINE_WORDS - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_miss      = 1'b0;
    w_word_done = 1'b0;
    w_ready     = 1'b0;
    w_rdata     = 32'd0;
    case (r_state)
      S_CLEAR: begin
        if (r_clr_cnt == INDEX_BITS'(LINES - 1)) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (r_pending || i_invalidate) begin
          w_next = S_CLEAR;
        end else if (!i_stall) begin
          w_accept = 1'b1;
          w_next   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (r_rd_valid && (r_rd_tag == w_tag)) begin
          w_ready = 1'b1;
          w_rdata = r_rd_word;
          w_next  = S_IDLE;
        end else begin
          w_miss = 1'b1;
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        if (i_bus_ready) begin
          w_word_done = 1'b1;
          if (w_is_last) begin
            // Requested word may be arriving right now rather than already captured
            w_ready = 1'b1;
            w_rdata = (w_offset == r_fill_cnt) ? i_bus_rdata : r_ret;
            w_next  = S_IDLE;
          end else begin
            w_next = S_GAP;
          end
        end
      end
      S_GAP:   w_next = S_FILL;
      default: w_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pc          <= 32'd0;
      r_pending     <= 1'b0;
      r_clr_cnt     <= '0;
      r_fill_cnt    <= '0;
      r_ret         <= 32'd0;
      r_bus_address <= 32'd0;
    end else begin
      if (w_accept) r_pc <= i_input_pc;
      if ((r_state == S_IDLE) && (w_next == S_CLEAR)) begin
        r_pending <= 1'b0;
      end else if (i_invalidate && (r_state != S_CLEAR)) begin
        r_pending <= 1'b1;
      end
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + INDEX_BITS'(1);
      if (w_miss) begin
        r_fill_cnt    <= '0;
        r_bus_address <= w_line_base;
      end
      if (w_word_done) begin
        if (r_fill_cnt == w_offset) r_ret <= i_bus_rdata;
        if (!w_is_last) begin
          r_fill_cnt    <= r_fill_cnt + OW'(1);
          r_bus_address <= w_line_base | (32'(r_fill_cnt + OW'(1)) << 2);
        end
      end
    end
  end

  // Tag/valid/data arrays; not reset, the sweep establishes valid bits
  always_ff @(posedge i_clock) begin
    if (r_state == S_CLEAR) r_valid[r_clr_cnt] <= 1'b0;
    if (w_word_done) r_data_mem[w_fill_daddr] <= i_bus_rdata;
    if (w_word_done && w_is_last) begin
      r_valid[w_index]   <= 1'b1;
      r_tag_mem[w_index] <= w_tag;
    end
    if (w_accept) begin
      r_rd_valid <= r_valid[w_acc_index];
      r_rd_tag   <= r_tag_mem[w_acc_index];
      r_rd_word  <= r_data_mem[w_acc_daddr];
    end
  end

  assign o_ready       = w_ready;
  assign o_rdata       = w_rdata;
  assign o_busy        = (r_state == S_CLEAR);
  assign o_bus_request = (r_state == S_FILL);
  assign o_bus_address = r_bus_address;

endmodule

// File: doc/cpu_icache_burst.md
# cpu_icache_burst

Parametrised direct-mapped instruction cache with multi-word lines, sitting between the fetch stage and the instruction bus. It generalises the single-word tagged fetch cache in three ways: configurable line length with burst refill, configurable depth, and an explicit invalidate (fence.i) that sweeps all valid bits. Fetch-side handshake (pc, stall, ready, rdata) and bus-side handshake (request, ready, address, rdata) keep the existing CPU conventions.

## Interface
- INDEX_BITS, 8, log2 of number of lines (1..12)
- LINE_WORDS, 4, 32-bit words per line; power of two, 1..16; W = log2(LINE_WORDS)
- i_clock  in  1  single clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_input_pc  in  32  fetch address; bits [1:0] ignored; held stable from accept until o_ready
- i_stall  in  1  pipeline stall; no new fetch accepted while high
- i_invalidate  in  1  single-cycle request to invalidate the entire cache
- o_ready  out  1  one-cycle pulse: o_rdata valid for i_input_pc
- o_rdata  out  32  fetched instruction; 0 when o_ready low
- o_busy  out  1  high while invalidation sweep runs
- o_bus_request  out  1  bus read request
- i_bus_ready  in  1  one-cycle pulse: i_bus_rdata valid, transfer complete
- o_bus_address  out  32  word-aligned bus read address
- i_bus_rdata  in  32  bus read data

## Operation
- Address split: offset = pc[W+1:2], index = pc[W+INDEX_BITS+1:W+2], tag = pc[31:W+INDEX_BITS+2].
- Storage: valid bit + tag per line; LINE_WORDS data words per line; synchronous read, one-cycle latency.
- States: CLEAR, IDLE, LOOKUP, FILL, GAP.
- CLEAR: clear-counter walks 0..2^INDEX_BITS-1, one valid bit cleared per cycle; o_busy=1; after last index -> IDLE. No fetch accepted.
- IDLE: if invalidate pending -> CLEAR (priority over fetch). Else if !i_stall -> accept fetch, launch tag/data read -> LOOKUP. Else stay.
- LOOKUP: hit = valid && stored tag == tag. Hit: o_ready=1, o_rdata = stored word[offset] -> IDLE. Miss: fill-counter=0 -> FILL.
- FILL: o_bus_request=1, o_bus_address = {pc[31:W+2], fill-counter, 2'b00}. On i_bus_ready: write word at fill-counter; if word index == offset, capture into return register. If not last word -> GAP, counter+1. If last word: write tag, set valid, o_ready=1, o_rdata = requested word (from bus directly if offset is last word, else return register) -> IDLE.
- GAP: request low one cycle (bus slave re-arm) -> FILL.
- Refill always line-aligned, word 0 first, ascending; never wraps mid-line.
- i_invalidate: in any state other than CLEAR, sets a pending flag; flag serviced at next IDLE. A fill in progress completes and delivers o_ready; the freshly filled line is then cleared. i_invalidate during CLEAR restarts nothing (ignored).
- i_stall only gates acceptance in IDLE; once accepted, fetch completes regardless of i_stall.

## Timing
- Reset (asynchronous): state=CLEAR, clear-counter=0, pending=0, fill-counter=0; o_ready=0, o_rdata=0, o_bus_request=0, o_bus_address=0, o_busy=1 immediately while i_reset high. Reset mid-fill drops o_bus_request asynchronously; partial line stays invalid.
- After reset release: o_busy high exactly 2^INDEX_BITS cycles, then first fetch acceptable.
- Hit: accept in cycle N (IDLE), o_ready in N+1; next accept N+2 (one fetch per 2 cycles).
- Miss: request in N+2; per-word cost = bus latency + 1 GAP cycle; o_ready coincides with the last i_bus_ready.
- o_bus_address stable whenever o_bus_request high; changes only in GAP.
- i_bus_ready while o_bus_request low is ignored.

## Test plan
- INDEX_BITS=4, LINE_WORDS=4, reset pulse -> o_busy high 16 cycles, no o_ready/o_bus_request, then fetch accepted.
- Miss pc=0x1008, slave returns 0xA0,0xA1,0xA2,0xA3 with 2-cycle latency -> addresses 0x1000,0x1004,0x1008,0x100C with one low-request cycle between; o_ready on 4th ready, o_rdata=0xA2.
- Following fetch pc=0x100C -> o_ready one cycle after accept, o_rdata=0xA3, o_bus_request never asserted; i_stall high in IDLE for 5 cycles -> no o_ready, no request.
- Conflict: pc=0x1100 (index 0, tag 0x11) after 0x1000 filled -> full refill; then pc=0x1000 misses again and refills.
- i_invalidate pulsed during 2nd word of fill of 0x1000 -> fill completes, o_ready with correct word, then o_busy 16 cycles, then pc=0x1000 misses.
- i_reset asserted during 3rd word of fill -> o_bus_request low same cycle, o_busy high; after sweep, pc of that line misses.
